// File: rtl/formula_traffic_gen.sv
// Traffic generator/checker for the ((a-b)*(1+3c)+4d)>>>1 pipeline: issues LFSR operand
// tuples, queues the expected results in order and scores the returned stream.
module formula_traffic_gen #(
  parameter int          WIDTH = 8,
  parameter int          DEPTH = 4,
  parameter logic [31:0] SEED  = 32'h0403_0105
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [15:0]               num_tx,
  input  logic [7:0]                stall_mask,
  output logic signed [WIDTH-1:0]   a,
  output logic signed [WIDTH-1:0]   b,
  output logic signed [WIDTH-1:0]   c,
  output logic signed [WIDTH-1:0]   d,
  output logic                      in_valid,
  input  logic                      in_ready,
  input  logic signed [2*WIDTH+2:0] q,
  input  logic                      out_valid,
  output logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               err_count,
  output logic [15:0]               rx_count
);
  localparam int          RW   = 2*WIDTH+3;
  localparam int          AW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LOAD = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic signed [RW-1:0] ONE   = RW'(1);
  localparam logic signed [RW-1:0] THREE = RW'(3);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [31:0]            lfsr_reg;
  logic [15:0]            num_reg, sent_reg;
  logic [2:0]             ph_reg;
  logic [AW:0]            count_reg;
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic signed [RW-1:0]   fifo_mem [DEPTH];

  logic                   start_go, push, res_hs, pop, unexpected, mismatch;
  logic signed [RW-1:0]   sa, sb, sc, sd, sum, expected;

  assign a = lfsr_reg[WIDTH-1:0];
  assign b = lfsr_reg[8 +: WIDTH];
  assign c = lfsr_reg[16 +: WIDTH];
  assign d = lfsr_reg[24 +: WIDTH];

  // Operands widened to the result width before any arithmetic so nothing overflows.
  assign sa       = {{(RW-WIDTH){a[WIDTH-1]}}, a};
  assign sb       = {{(RW-WIDTH){b[WIDTH-1]}}, b};
  assign sc       = {{(RW-WIDTH){c[WIDTH-1]}}, c};
  assign sd       = {{(RW-WIDTH){d[WIDTH-1]}}, d};
  assign sum      = (sa - sb) * (ONE + THREE * sc) + (sd <<< 2);
  assign expected = sum >>> 1;

  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);
  assign out_ready = busy && !stall_mask[ph_reg];
  assign in_valid  = (state_reg == RUN) && (sent_reg != num_reg) && (count_reg != FULL);

  assign start_go   = start && !busy;
  assign push       = in_valid && in_ready;
  assign res_hs     = out_valid && out_ready;
  assign pop        = res_hs && (count_reg != '0);
  assign unexpected = res_hs && (count_reg == '0);
  assign mismatch   = pop && (fifo_mem[rd_ptr_reg] != q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = (num_tx == 16'd0) ? DONE : RUN;
      RUN:        if (sent_reg == num_reg) state_next = DRAIN;
      DRAIN:      if (rx_count == num_reg) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg   <= LOAD;
      num_reg    <= '0;
      sent_reg   <= '0;
      ph_reg     <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      err_count  <= '0;
      rx_count   <= '0;
    end else begin
      if (busy) ph_reg <= ph_reg + 3'd1;
      if (start_go) begin
        lfsr_reg   <= LOAD;
        num_reg    <= num_tx;
        sent_reg   <= '0;
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        err_count  <= '0;
        rx_count   <= '0;
      end else begin
        if (push) begin
          lfsr_reg   <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? POLY : 32'h0);
          sent_reg   <= sent_reg + 16'd1;
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          rx_count   <= rx_count + 16'd1;
        end
        // Simultaneous push and pop leaves occupancy unchanged, even when full.
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
        if ((mismatch || unexpected) && (err_count != 16'hFFFF))
          err_count <= err_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= expected;
  end
endmodule

// File: tb/tb_formula_traffic_gen.sv
// Directed bench: a behavioural pipeline sink plus a queue-based reference model that is
// compared against the generator outputs on every cycle.
module tb_formula_traffic_gen;
  localparam int          W    = 8;
  localparam int          D    = 4;
  localparam int          RW   = 2*W+3;
  localparam logic [31:0] SEED = 32'h0403_0105;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [15:0]          num_tx = '0;
  logic [7:0]           stall_mask = '0;
  logic signed [W-1:0]  a, b, c, d;
  logic                 in_valid;
  logic                 in_ready = 1'b0;
  logic signed [RW-1:0] q = '0;
  logic                 out_valid = 1'b0;
  logic                 out_ready, busy, done;
  logic [15:0]          err_count, rx_count;

  always #5 clk = ~clk;

  formula_traffic_gen #(.WIDTH(W), .DEPTH(D), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tx(num_tx), .stall_mask(stall_mask),
    .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .err_count(err_count), .rx_count(rx_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] formula(input logic [7:0] ua, ub, uc, ud);
    int sa, sb, sc, sd, r;
    sa = $signed(ua); sb = $signed(ub); sc = $signed(uc); sd = $signed(ud);
    r = ((sa - sb) * (1 + 3*sc) + 4*sd) >>> 1;
    return r[RW-1:0];
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 32'h0);
  endfunction

  // Reference model state (0 idle, 1 run, 2 drain, 3 done).
  int          m_st, m_sent, m_rx, m_err, m_num, m_ph;
  logic [31:0] m_lfsr;
  logic [RW-1:0] m_q[$];

  // Pipeline sink state.
  logic [RW-1:0] pq[$];
  logic [RW-1:0] last_q;
  int  sink_cnt = 0;
  int  op_count = 0;
  int  ready_mode = 0;
  bit  corrupt10 = 0, hold = 0, inj_req = 0, inj_now = 0;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit exp_busy, exp_iv, exp_or, op_hs, res_hs;
        int nst;
        logic [RW-1:0] e, r;
        if (!rst_n) begin
          m_st = 0; m_sent = 0; m_rx = 0; m_err = 0; m_num = 0; m_ph = 0;
          m_lfsr = SEED; m_q.delete(); pq.delete();
        end
        exp_busy = (m_st == 1) || (m_st == 2);
        exp_iv   = (m_st == 1) && (m_sent < m_num) && (m_q.size() < D);
        exp_or   = exp_busy && !stall_mask[m_ph];
        chk("a", $unsigned(a), m_lfsr[7:0]);
        chk("b", $unsigned(b), m_lfsr[15:8]);
        chk("c", $unsigned(c), m_lfsr[23:16]);
        chk("d", $unsigned(d), m_lfsr[31:24]);
        chk("in_valid", in_valid, exp_iv);
        chk("out_ready", out_ready, exp_or);
        chk("busy", busy, exp_busy);
        chk("done", done, m_st == 3);
        chk("err_count", err_count, m_err);
        chk("rx_count", rx_count, m_rx);
        if (rst_n) begin
          op_hs  = exp_iv && in_ready;
          res_hs = out_valid && exp_or;
          if ((m_st == 0 || m_st == 3) && start) begin
            m_num = num_tx; m_sent = 0; m_rx = 0; m_err = 0;
            m_q.delete(); m_lfsr = SEED;
            m_st = (num_tx == 0) ? 3 : 1;
          end else begin
            nst = m_st;
            if (m_st == 1 && m_sent == m_num) nst = 2;
            else if (m_st == 2 && m_rx == m_num) nst = 3;
            if (res_hs) begin
              if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_rx++;
                if (q !== e && m_err < 65535) m_err++;
              end else if (m_err < 65535) m_err++;
              if (pq.size() > 0 && !inj_now) void'(pq.pop_front());
            end
            if (op_hs) begin
              m_q.push_back(formula(m_lfsr[7:0], m_lfsr[15:8], m_lfsr[23:16], m_lfsr[31:24]));
              m_lfsr = lfsr_step(m_lfsr);
              m_sent++;
              r = formula($unsigned(a), $unsigned(b), $unsigned(c), $unsigned(d));
              sink_cnt++;
              if (corrupt10 && (sink_cnt % 10 == 0)) r = r + 1'b1;
              last_q = r;
              pq.push_back(r);
              op_count++;
            end
            m_st = nst;
          end
          if (exp_busy) m_ph = (m_ph + 1) % 8;
        end
      end
      @(posedge clk); #1;
      inj_now = 0;
      if (!rst_n) out_valid = 1'b0;
      else if (inj_req) begin
        out_valid = 1'b1; q = '0; inj_now = 1; inj_req = 0;
      end else begin
        out_valid = !hold && (pq.size() > 0);
        q = (pq.size() > 0) ? pq[0] : '0;
      end
      in_ready = (ready_mode == 1) ? 1'b1 :
                 (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic do_start(input int n);
    @(posedge clk); #1;
    op_count = 0; sink_cnt = 0;
    num_tx = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk({name, "_done"}, done, 1);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a", $unsigned(a), 8'h05);
    chk("rst_d", $unsigned(d), 8'h04);
    chk("rst_busy", busy, 0);
    chk("rst_in_valid", in_valid, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Single tuple with the default seed.
    ready_mode = 1; stall_mask = 8'h00;
    do_start(1);
    chk("t1_in_valid", in_valid, 1);
    chk("t1_a", $unsigned(a), 5);
    chk("t1_b", $unsigned(b), 1);
    chk("t1_c", $unsigned(c), 3);
    chk("t1_d", $unsigned(d), 4);
    wait_done("t1", 50, cyc);
    chk("t1_q", last_q, 28);
    chk("t1_err", err_count, 0);
    chk("t1_rx", rx_count, 1);
    $display("txn t1 num_tx=1 q=%0d rx=%0d err=%0d", last_q, rx_count, err_count);

    // Full throughput.
    do_start(100);
    wait_done("t2", 400, cyc);
    chk("t2_cycles", cyc, 102);
    chk("t2_ops", op_count, 100);
    chk("t2_rx", rx_count, 100);
    chk("t2_err", err_count, 0);
    $display("txn t2 num_tx=100 cycles=%0d rx=%0d err=%0d", cyc, rx_count, err_count);

    // Alternating backpressure with random operand acceptance.
    stall_mask = 8'hAA; ready_mode = 2;
    do_start(40);
    wait_done("t3", 2000, cyc);
    chk("t3_rx", rx_count, 40);
    chk("t3_err", err_count, 0);
    $display("txn t3 num_tx=40 mask=aa rx=%0d err=%0d", rx_count, err_count);

    // Every 10th result corrupted.
    stall_mask = 8'h00; ready_mode = 1; corrupt10 = 1;
    do_start(50);
    wait_done("t4", 500, cyc);
    chk("t4_err", err_count, 5);
    chk("t4_rx", rx_count, 50);
    corrupt10 = 0;
    $display("txn t4 num_tx=50 corrupt rx=%0d err=%0d", rx_count, err_count);

    // Results withheld: issue must stop at FIFO depth.
    hold = 1;
    do_start(10);
    repeat (20) begin @(posedge clk); #1; end
    chk("t5_ops", op_count, D);
    chk("t5_in_valid", in_valid, 0);
    hold = 0;
    wait_done("t5", 200, cyc);
    chk("t5_rx", rx_count, 10);
    chk("t5_err", err_count, 0);
    $display("txn t5 hold ops_before_release=%0d rx=%0d err=%0d", D, rx_count, err_count);

    // Zero-length run.
    do_start(0);
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    chk("t6_ops", op_count, 0);
    $display("txn t6 num_tx=0 done=%0d", done);

    // Unexpected result while the FIFO is empty.
    ready_mode = 0;
    do_start(3);
    inj_req = 1;
    repeat (4) begin @(posedge clk); #1; end
    ready_mode = 1;
    wait_done("t7", 200, cyc);
    chk("t7_err", err_count, 1);
    chk("t7_rx", rx_count, 3);
    $display("txn t7 unexpected rx=%0d err=%0d", rx_count, err_count);

    // Reset mid-run, then a clean recovery run.
    do_start(100);
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t8_busy", busy, 0);
    chk("t8_in_valid", in_valid, 0);
    chk("t8_out_ready", out_ready, 0);
    chk("t8_rx", rx_count, 0);
    chk("t8_a", $unsigned(a), 5);
    @(posedge clk); #1; rst_n = 1'b1;
    do_start(5);
    wait_done("t8", 100, cyc);
    chk("t8_rx_after", rx_count, 5);
    chk("t8_err_after", err_count, 0);
    $display("txn t8 reset-recover rx=%0d err=%0d", rx_count, err_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
